imem_fetch_ctrl: RTL

Fetch sequencer and port owner for the single-port instruction memory. Holds the program counter, drives the memory address, and registers the fetched word into the IF/ID boundary. Applies stall, branch and jump redirects from decode/execute, and squashes wrong-path fetches. Also arbitrates the memory's write side so that a streaming program loader can fill memory before execution starts.

---
 rtl/imem_fetch_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Fetch sequencer and sole owner of the single-port instruction memory.
//   The block holds the PC and drives the memory address. It registers each
//   fetched word into the IF/ID boundary and applies stall and redirect
//   requests from decode/execute. Between runs it also gives the memory's
//   write side to a streaming program loader.
//
//   Optional feature macro: IMEM_FAULT_EN
//     When it is defined, the block gains a FAULT state and a `fault` output.
//     In that build, a selected next PC that is unaligned or outside the
//     memory parks the sequencer in FAULT until reset.
//
//   Loader handshake (valid/ready):
//     A word transfers on a rising edge where load_valid && load_ready.
//     load_ready depends only on the state, never on load_valid.
//     The loader must hold load_data and load_last stable while
//     load_valid is high and the word has not yet transferred.
//
//   fsm_state is a debug view of the sequencer state register.

module imem_fetch_ctrl #(
  parameter int unsigned MEM_SIZE = 256,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_ovf,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc4,
  output logic        instr_valid,
  output logic        running,
  output logic        halted,
`ifdef IMEM_FAULT_EN
  output logic        fault,
`endif
  output logic [2:0]  fsm_state
);

  localparam logic [31:0] MEM_END = 32'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3
`ifdef IMEM_FAULT_EN
    ,
    S_FAULT = 3'd4
`endif
  } state_t;

  state_t      state;
  logic [31:0] wr_cnt;
  logic [31:0] pc_seq;
  logic [31:0] next_pc;
  logic        wr_ok;
  logic        load_fire;

  // Sequential successor and redirect selection. Jump outranks branch.
  // Stall and halt are resolved in the state machine, which has the
  // higher priority.
  always_comb begin
    pc_seq  = pc + 32'd4;
    next_pc = pc_seq;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

`ifdef IMEM_FAULT_EN
  logic next_pc_bad;
  assign next_pc_bad = (next_pc[1:0] != 2'b00) || (next_pc >= MEM_END);
`endif

  // The write counter stops at MEM_END. Words that arrive past the end
  // are still accepted, so the loader never stalls, but they are dropped.
  assign wr_ok     = (wr_cnt < MEM_END);
  assign load_fire = (state == S_LOAD) && load_valid;

  // The loader owns the memory port only while the state is LOAD.
  // In every other state the port fetches at the PC.
  assign imem_we    = load_fire && wr_ok;
  assign imem_addr  = (state == S_LOAD) ? wr_cnt : pc;
  assign imem_wdata = load_data;
  assign fsm_state  = state;

  // Sequencer: state, PC, IF/ID register, loader counter and the
  // registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc4   <= '0;
      instr_valid <= 1'b0;
      wr_cnt      <= '0;
      load_ovf    <= 1'b0;
      load_ready  <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
`ifdef IMEM_FAULT_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            running     <= 1'b1;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
          end else if (load_valid) begin
            state      <= S_LOAD;
            load_ready <= 1'b1;
            wr_cnt     <= '0;
          end
        end

        S_LOAD: begin
          if (load_valid) begin
            if (wr_ok) begin
              wr_cnt <= wr_cnt + 32'd4;
            end else begin
              load_ovf <= 1'b1;
            end
            if (load_last) begin
              state      <= S_IDLE;
              load_ready <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (halt_req) begin
            // Drop the word on the bus this cycle and freeze the PC.
            state       <= S_HALT;
            running     <= 1'b0;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
          end else if (!stall) begin
`ifdef IMEM_FAULT_EN
            if (next_pc_bad) begin
              // Keep the last good PC so the faulting context is visible.
              state       <= S_FAULT;
              running     <= 1'b0;
              fault       <= 1'b1;
              instr_valid <= 1'b0;
            end else
`endif
            begin
              pc          <= next_pc;
              instr       <= imem_rdata;
              instr_pc4   <= pc_seq;
              // A redirect kills the word fetched alongside it (no delay slot).
              instr_valid <= !(jump || branch_taken);
            end
          end
        end

        S_HALT: begin
          if (start) begin
            state       <= S_RUN;
            running     <= 1'b1;
            halted      <= 1'b0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
          end
        end

`ifdef IMEM_FAULT_EN
        S_FAULT: begin
          instr_valid <= 1'b0;
        end
`endif

        default: begin
          state       <= S_IDLE;
          load_ready  <= 1'b0;
          running     <= 1'b0;
          halted      <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
